// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: scoreboard entry layout,
// pipeline register indices and the forward-select encoding.
package pipe_pkg;

    localparam int SB_RA_W     = 5;
    localparam int FWD_REGFILE = 0;
    localparam int IFID_IDX    = 0;
    localparam int IDEX_IDX    = 1;

    typedef struct packed {
        logic               valid;
        logic [SB_RA_W-1:0] rd;
        logic               rd_we;
        logic               is_load;
    } sb_entry_t;

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Youngest-match priority search over scoreboard entries 2..NUM_PREGS-1
// selecting the EX operand source for one source register.
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int NUM_PREGS = 4,
    parameter int LU_DEPTH  = 1,
    parameter int RA_W      = SB_RA_W,
    parameter int FS_W      = $clog2(NUM_PREGS)
) (
    input  sb_entry_t         sb_i [NUM_PREGS-2],
    input  logic [RA_W-1:0]   rs_i,
    input  logic              used_i,
    output logic [FS_W-1:0]   sel_o,
    output logic              blocked_o
);

    logic hit;

    // A load still in flight shadows any older writer of the same rd.
    always_comb begin
        sel_o     = FS_W'(FWD_REGFILE);
        blocked_o = 1'b0;
        hit       = 1'b0;
        for (int k = 2; k < NUM_PREGS; k++) begin
            if (!hit && used_i && rs_i != '0
                && sb_i[k-2].valid && sb_i[k-2].rd_we
                && sb_i[k-2].rd == rs_i) begin
                hit = 1'b1;
                if (sb_i[k-2].is_load && k < LU_DEPTH + 2)
                    blocked_o = 1'b1;
                else
                    sel_o = FS_W'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: valid bits, rd scoreboard, stalls, flushes, forwarding.
// PIPE_CTRL_PERF_EN builds the stall/flush performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_PREGS = 4,
    parameter int LU_DEPTH  = 1,
    parameter int RA_W      = SB_RA_W,
    parameter int FS_W      = $clog2(NUM_PREGS)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 IF_VALID,
    input  logic [RA_W-1:0]      ID_RS1_ADDR,
    input  logic [RA_W-1:0]      ID_RS2_ADDR,
    input  logic                 ID_RS1_USED,
    input  logic                 ID_RS2_USED,
    input  logic [RA_W-1:0]      ID_RD_ADDR,
    input  logic                 ID_RD_WE,
    input  logic                 ID_IS_LOAD,
    input  logic                 EX_BRANCH_TAKEN,
    input  logic                 MEM_BUSYWAIT,
    output logic                 PC_HOLD,
    output logic [NUM_PREGS-1:0] PREG_EN,
    output logic [NUM_PREGS-1:0] PREG_VALID,
    output logic                 LU_HAZARD,
    output logic [FS_W-1:0]      FWD_SEL1,
    output logic [FS_W-1:0]      FWD_SEL2,
    output logic [31:0]          STALL_CYCLES,
    output logic [31:0]          FLUSH_COUNT
);

    logic            valid0_q, valid0_d;
    sb_entry_t       sb_q [1:NUM_PREGS-1];
    sb_entry_t       sb_d [1:NUM_PREGS-1];
    sb_entry_t       sb_old [NUM_PREGS-2];
    logic [RA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic            rs1_used_q, rs1_used_d;
    logic            rs2_used_q, rs2_used_d;
    logic            freeze, flush, lu_cond, stall_lu;
    logic            blk1, blk2;

    assign freeze = MEM_BUSYWAIT;
    assign flush  = EX_BRANCH_TAKEN & ~freeze;

    always_comb begin
        lu_cond = 1'b0;
        for (int k = 1; k <= LU_DEPTH; k++) begin
            if (sb_q[k].valid && sb_q[k].is_load && sb_q[k].rd_we
                && sb_q[k].rd != '0
                && ((ID_RS1_USED && ID_RS1_ADDR == sb_q[k].rd)
                 || (ID_RS2_USED && ID_RS2_ADDR == sb_q[k].rd)))
                lu_cond = 1'b1;
        end
        lu_cond = lu_cond & valid0_q;
    end

    assign stall_lu  = lu_cond & ~freeze & ~flush;
    assign LU_HAZARD = stall_lu;
    assign PC_HOLD   = RESET & (freeze | stall_lu);

    always_comb begin
        PREG_EN = '1;
        if (freeze)
            PREG_EN = '0;
        else if (stall_lu)
            PREG_EN[IFID_IDX] = 1'b0;
    end

    always_comb begin
        PREG_VALID[IFID_IDX] = valid0_q;
        for (int k = 1; k < NUM_PREGS; k++)
            PREG_VALID[k] = sb_q[k].valid;
    end

    // Register 1 takes either the IF/ID instruction or a bubble.
    always_comb begin
        valid0_d   = valid0_q;
        sb_d       = sb_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_used_d = rs1_used_q;
        rs2_used_d = rs2_used_q;
        if (!freeze) begin
            sb_d[IDEX_IDX].valid   = valid0_q & ~flush & ~stall_lu;
            sb_d[IDEX_IDX].rd      = ID_RD_ADDR;
            sb_d[IDEX_IDX].rd_we   = ID_RD_WE;
            sb_d[IDEX_IDX].is_load = ID_IS_LOAD;
            rs1_d      = ID_RS1_ADDR;
            rs2_d      = ID_RS2_ADDR;
            rs1_used_d = ID_RS1_USED;
            rs2_used_d = ID_RS2_USED;
            for (int k = 2; k < NUM_PREGS; k++)
                sb_d[k] = sb_q[k-1];
            if (flush)
                valid0_d = 1'b0;
            else if (!stall_lu)
                valid0_d = IF_VALID;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid0_q   <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_used_q <= 1'b0;
            rs2_used_q <= 1'b0;
            for (int k = 1; k < NUM_PREGS; k++)
                sb_q[k] <= '0;
        end else begin
            valid0_q   <= valid0_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_used_q <= rs1_used_d;
            rs2_used_q <= rs2_used_d;
            sb_q       <= sb_d;
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_PREGS - 2; j++)
            sb_old[j] = sb_q[j+2];
    end

    pipe_fwd_sel #(
        .NUM_PREGS (NUM_PREGS),
        .LU_DEPTH  (LU_DEPTH),
        .RA_W      (RA_W),
        .FS_W      (FS_W)
    ) u_fwd1 (
        .sb_i      (sb_old),
        .rs_i      (rs1_q),
        .used_i    (rs1_used_q & sb_q[IDEX_IDX].valid),
        .sel_o     (FWD_SEL1),
        .blocked_o (blk1)
    );

    pipe_fwd_sel #(
        .NUM_PREGS (NUM_PREGS),
        .LU_DEPTH  (LU_DEPTH),
        .RA_W      (RA_W),
        .FS_W      (FS_W)
    ) u_fwd2 (
        .sb_i      (sb_old),
        .rs_i      (rs2_q),
        .used_i    (rs2_used_q & sb_q[IDEX_IDX].valid),
        .sel_o     (FWD_SEL2),
        .blocked_o (blk2)
    );

    // The load-use stall must keep young loads out of forwarding range.
    a_fwd_legal: assert property (
        @(posedge CLK) disable iff (!RESET) !(blk1 || blk2));

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, freeze | stall_lu};
        flush_cnt_d = flush_cnt_q + {31'd0, flush};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign STALL_CYCLES = stall_cnt_q;
    assign FLUSH_COUNT  = flush_cnt_q;
`else
    assign STALL_CYCLES = '0;
    assign FLUSH_COUNT  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance (4 regs, LU_DEPTH 1)
// and a deeper one (5 regs, LU_DEPTH 2) driven from the same inputs.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk, rst_n, if_valid, br, busy;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we, ld;

    logic        a_hold, a_lu;
    logic [3:0]  a_en, a_val;
    logic [1:0]  a_f1, a_f2;
    logic [31:0] a_stall, a_flush;

    logic        b_hold, b_lu;
    logic [4:0]  b_en, b_val;
    logic [2:0]  b_f1, b_f2;
    logic [31:0] b_stall, b_flush;

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl u_a (
        .CLK(clk), .RESET(rst_n), .IF_VALID(if_valid),
        .ID_RS1_ADDR(rs1), .ID_RS2_ADDR(rs2),
        .ID_RS1_USED(u1), .ID_RS2_USED(u2),
        .ID_RD_ADDR(rd), .ID_RD_WE(we), .ID_IS_LOAD(ld),
        .EX_BRANCH_TAKEN(br), .MEM_BUSYWAIT(busy),
        .PC_HOLD(a_hold), .PREG_EN(a_en), .PREG_VALID(a_val),
        .LU_HAZARD(a_lu), .FWD_SEL1(a_f1), .FWD_SEL2(a_f2),
        .STALL_CYCLES(a_stall), .FLUSH_COUNT(a_flush)
    );

    pipe_ctrl #(.NUM_PREGS(5), .LU_DEPTH(2)) u_b (
        .CLK(clk), .RESET(rst_n), .IF_VALID(if_valid),
        .ID_RS1_ADDR(rs1), .ID_RS2_ADDR(rs2),
        .ID_RS1_USED(u1), .ID_RS2_USED(u2),
        .ID_RD_ADDR(rd), .ID_RD_WE(we), .ID_IS_LOAD(ld),
        .EX_BRANCH_TAKEN(br), .MEM_BUSYWAIT(busy),
        .PC_HOLD(b_hold), .PREG_EN(b_en), .PREG_VALID(b_val),
        .LU_HAZARD(b_lu), .FWD_SEL1(b_f1), .FWD_SEL2(b_f2),
        .STALL_CYCLES(b_stall), .FLUSH_COUNT(b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] r1, input logic v1,
                          input logic [4:0] r2, input logic v2,
                          input logic [4:0] d, input logic w,
                          input logic l);
        rs1 = r1; u1 = v1; rs2 = r2; u2 = v2;
        rd = d; we = w; ld = l;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_valid = 1'b0; br = 1'b0; busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        #2;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; br = 1'b0; busy = 1'b0; if_valid = 1'b1;
        set_id(5'd3, 1, 5'd4, 1, 5'd3, 1, 1);
        #2;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (a_val !== 4'b0000) begin n_err++; $display("FAIL rst_valid: got %b want 0000", a_val); end
            n_cmp++; if (b_val !== 5'b00000) begin n_err++; $display("FAIL rst_valid_b: got %b want 00000", b_val); end
            n_cmp++; if (a_lu !== 1'b0 || a_hold !== 1'b0) begin n_err++; $display("FAIL rst_lu_hold: got %b%b want 00", a_lu, a_hold); end
            n_cmp++; if (a_en !== 4'b1111) begin n_err++; $display("FAIL rst_en: got %b want 1111", a_en); end
            n_cmp++; if (a_f1 !== 2'd0 || a_f2 !== 2'd0) begin n_err++; $display("FAIL rst_fwd: got %0d/%0d want 0/0", a_f1, a_f2); end
            n_cmp++; if (a_stall !== 32'd0 || a_flush !== 32'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", a_stall, a_flush); end
            tick();
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp_v [5];
        exp_v = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        do_reset();
        if_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (a_val !== exp_v[i]) begin n_err++; $display("FAIL fill_valid[%0d]: got %b want %b", i, a_val, exp_v[i]); end
            n_cmp++; if (a_en !== 4'b1111) begin n_err++; $display("FAIL fill_en[%0d]: got %b want 1111", i, a_en); end
            n_cmp++; if (a_f1 !== 2'd0 || a_f2 !== 2'd0) begin n_err++; $display("FAIL fill_fwd[%0d]: got %0d/%0d want 0/0", i, a_f1, a_f2); end
            tick();
        end
        n_cmp++; if (b_val !== 5'b11111) begin n_err++; $display("FAIL fill_valid_b: got %b want 11111", b_val); end
    endtask

    // add x5; sub x6,x5,x1; or x9,x5,x5; addi x9,x6 (rs2=x5 unused);
    // and x10,x9,x0; then a nop.
    task automatic test_fwd_alu();
        logic [4:0] t_r1 [6], t_r2 [6], t_rd [6];
        logic       t_u2 [6];
        logic [2:0] e1 [6], e2 [6];
        t_r1 = '{5'd1, 5'd5, 5'd5, 5'd6, 5'd9, 5'd0};
        t_r2 = '{5'd2, 5'd1, 5'd5, 5'd5, 5'd0, 5'd0};
        t_u2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        t_rd = '{5'd5, 5'd6, 5'd9, 5'd9, 5'd10, 5'd0};
        e1   = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd3, 3'd2};
        e2   = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0};
        do_reset();
        if_valid = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) set_id(t_r1[i], 1, t_r2[i], t_u2[i], t_rd[i], 1, 0);
            else set_id(0, 0, 0, 0, 0, 0, 0);
            #1;
            n_cmp++; if ({1'b0, a_f1} !== e1[i] || {1'b0, a_f2} !== e2[i]) begin n_err++; $display("FAIL fwd_a[%0d]: got %0d/%0d want %0d/%0d", i, a_f1, a_f2, e1[i], e2[i]); end
            n_cmp++; if (b_f1 !== e1[i] || b_f2 !== e2[i]) begin n_err++; $display("FAIL fwd_b[%0d]: got %0d/%0d want %0d/%0d", i, b_f1, b_f2, e1[i], e2[i]); end
            n_cmp++; if (a_lu !== 1'b0 || a_hold !== 1'b0) begin n_err++; $display("FAIL fwd_nostall[%0d]: got %b%b want 00", i, a_lu, a_hold); end
            tick();
        end
    endtask

    task automatic test_load_use_a();
        do_reset();
        if_valid = 1'b1;
        tick();
        set_id(5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
        tick();
        set_id(5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
        #1;
        n_cmp++; if (a_lu !== 1'b1 || a_hold !== 1'b1) begin n_err++; $display("FAIL lu1_stall: got %b%b want 11", a_lu, a_hold); end
        n_cmp++; if (a_en !== 4'b1110) begin n_err++; $display("FAIL lu1_en: got %b want 1110", a_en); end
        tick();
        n_cmp++; if (a_val !== 4'b0101) begin n_err++; $display("FAIL lu1_bubble: got %b want 0101", a_val); end
        n_cmp++; if (a_lu !== 1'b0 || a_en !== 4'b1111) begin n_err++; $display("FAIL lu1_release: got %b/%b want 0/1111", a_lu, a_en); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (a_val !== 4'b1011) begin n_err++; $display("FAIL lu1_valid: got %b want 1011", a_val); end
        n_cmp++; if (a_f1 !== 2'd3 || a_f2 !== 2'd3) begin n_err++; $display("FAIL lu1_fwd: got %0d/%0d want 3/3", a_f1, a_f2); end
        n_cmp++; if (a_stall !== (PERF ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL lu1_stallcnt: got %0d want %0d", a_stall, PERF); end
    endtask

    task automatic test_load_use_b();
        do_reset();
        if_valid = 1'b1;
        tick();
        set_id(5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
        tick();
        set_id(5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (b_lu !== 1'b1 || b_hold !== 1'b1) begin n_err++; $display("FAIL lu2_stall[%0d]: got %b%b want 11", i, b_lu, b_hold); end
            n_cmp++; if (b_en !== 5'b11110) begin n_err++; $display("FAIL lu2_en[%0d]: got %b want 11110", i, b_en); end
            tick();
        end
        n_cmp++; if (b_val !== 5'b01001) begin n_err++; $display("FAIL lu2_bubbles: got %b want 01001", b_val); end
        n_cmp++; if (b_lu !== 1'b0 || b_en !== 5'b11111) begin n_err++; $display("FAIL lu2_release: got %b/%b want 0/11111", b_lu, b_en); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (b_val !== 5'b10011) begin n_err++; $display("FAIL lu2_valid: got %b want 10011", b_val); end
        n_cmp++; if (b_f1 !== 3'd4 || b_f2 !== 3'd4) begin n_err++; $display("FAIL lu2_fwd: got %0d/%0d want 4/4", b_f1, b_f2); end
        n_cmp++; if (b_stall !== (PERF ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL lu2_stallcnt: got %0d want %0d", b_stall, PERF ? 2 : 0); end
    endtask

    task automatic test_flush_lu();
        do_reset();
        if_valid = 1'b1;
        tick();
        set_id(5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
        tick();
        set_id(5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
        br = 1'b1;
        #1;
        n_cmp++; if (a_lu !== 1'b0 || a_hold !== 1'b0) begin n_err++; $display("FAIL flush_nostall: got %b%b want 00", a_lu, a_hold); end
        n_cmp++; if (a_en !== 4'b1111) begin n_err++; $display("FAIL flush_en: got %b want 1111", a_en); end
        tick();
        br = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (a_val !== 4'b0100) begin n_err++; $display("FAIL flush_valid: got %b want 0100", a_val); end
        n_cmp++; if (a_f1 !== 2'd0 || a_f2 !== 2'd0) begin n_err++; $display("FAIL flush_fwd: got %0d/%0d want 0/0", a_f1, a_f2); end
        n_cmp++; if (a_flush !== (PERF ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL flush_cnt: got %0d want %0d", a_flush, PERF); end
        n_cmp++; if (a_stall !== 32'd0) begin n_err++; $display("FAIL flush_stallcnt: got %0d want 0", a_stall); end
    endtask

    task automatic test_freeze();
        do_reset();
        if_valid = 1'b1;
        repeat (4) tick();
        br = 1'b1;
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (a_en !== 4'b0000 || a_hold !== 1'b1) begin n_err++; $display("FAIL frz_en[%0d]: got %b/%b want 0000/1", i, a_en, a_hold); end
            n_cmp++; if (a_val !== 4'b1111) begin n_err++; $display("FAIL frz_valid[%0d]: got %b want 1111", i, a_val); end
            tick();
        end
        busy = 1'b0;
        #1;
        n_cmp++; if (a_en !== 4'b1111 || a_hold !== 1'b0) begin n_err++; $display("FAIL frz_flush_en: got %b/%b want 1111/0", a_en, a_hold); end
        n_cmp++; if (a_val !== 4'b1111) begin n_err++; $display("FAIL frz_held: got %b want 1111", a_val); end
        tick();
        br = 1'b0;
        #1;
        n_cmp++; if (a_val !== 4'b1100) begin n_err++; $display("FAIL frz_flushed: got %b want 1100", a_val); end
        n_cmp++; if (a_flush !== (PERF ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL frz_flushcnt: got %0d want %0d", a_flush, PERF); end
        n_cmp++; if (a_stall !== (PERF ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL frz_stallcnt: got %0d want %0d", a_stall, PERF ? 3 : 0); end
        busy = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_val !== 4'b0000 || b_val !== 5'b00000) begin n_err++; $display("FAIL async_rst: got %b/%b want 0000/00000", a_val, b_val); end
        n_cmp++; if (a_hold !== 1'b0) begin n_err++; $display("FAIL async_rst_hold: got %b want 0", a_hold); end
        n_cmp++; if (a_stall !== 32'd0 || a_flush !== 32'd0) begin n_err++; $display("FAIL async_rst_cnt: got %0d/%0d want 0/0", a_stall, a_flush); end
        busy = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_fwd_alu();
        test_load_use_a();
        test_load_use_b();
        test_flush_lu();
        test_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
